bidir_frame_serdes: RTL and testbench
=====================================

# bidir_frame_serdes

Parametrised full-duplex frame serializer/deserializer. Successor to the fixed 48-bit TX / 16-bit RX gyro channel: frame widths, divider width and sync placement are generic, RX back-pressure and overflow are handled, and TX `tlast` is carried through to RX. It sits between the TX/RX AXI-Stream FIFOs and the `DTX`/`DRX`/`DSYNC`/`txclk` pins. Static configuration comes from the AXI-Lite register block as plain inputs.

## Interface
- `TX_WIDTH`, 48: TX frame payload bits.
- `RX_WIDTH`, 16: RX payload bits; must be ≤ `TX_WIDTH` (elaboration assertion).
- `DIV_W`, 8: `clk_div` width.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: allows new frames to start.
- `sck_pol` in 1: idle level of `txclk`.
- `clk_div` in `DIV_W`: half-bit period = `clk_div`+1 `clk` cycles.
- `s_axis_tdata` in `TX_WIDTH`; `s_axis_tvalid` in 1; `s_axis_tlast` in 1; `s_axis_tready` out 1.
- `m_axis_tdata` out `RX_WIDTH`; `m_axis_tvalid` out 1; `m_axis_tlast` out 1; `m_axis_tready` in 1.
- `txclk` out 1; `dtx` out 1; `dsync` out 1; `drx` in 1 (already synchronised upstream).
- `busy` out 1: high when the state is not IDLE.
- `rx_overflow` out 1: sticky. Cleared only by reset.
- `parity_err` out 1: sticky. Cleared only by reset.
- `frame_cnt` out 16: completed frames, wraps.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE:
  - `s_axis_tready` = `enable`.
  - On handshake, latch data, `tlast` and `clk_div`, then go to SHIFT with bit index 0.
- SHIFT:
  - Each bit period = 2·(`clk_div`+1) cycles.
  - Launch: at the start of a bit, `dtx` is driven MSB-first and `txclk` = `sck_pol`.
  - Sample: after `clk_div`+1 cycles, `txclk` toggles to `~sck_pol` and `drx` is sampled.
- `dsync` is high for exactly bit 0 of each frame.
- RX shifts in `drx` only in the last `RX_WIDTH` bit periods of the frame (payload region), MSB first.
- After the last bit, go to GAP for one bit period with `dtx`=0, `dsync`=0 and `txclk`=`sck_pol`. Then:
  - publish the RX word;
  - increment `frame_cnt`;
  - return to IDLE.
- RX publish:
  - If `m_axis_tvalid` is low, or `m_axis_tready` is high, load `m_axis_tdata` and `m_axis_tlast` (= latched TX `tlast`) and set `tvalid`.
  - Otherwise drop the word and set `rx_overflow`. The held word is unchanged.
- `m_axis_tvalid` clears on handshake unless a publish occurs in the same cycle.
- Changing `enable` or `clk_div` mid-frame does not affect the frame in flight. Deasserting `enable` stops after the current GAP.
- Back-to-back frames: the minimum spacing is one GAP bit period plus 1 IDLE cycle.

## Timing
- Reset values:
  - `txclk`=`sck_pol` (combinational from idle state); `dtx`=0; `dsync`=0.
  - `s_axis_tready`=0 for the first cycle (registered `enable`).
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0.
  - `busy`=0, `rx_overflow`=0, `parity_err`=0, `frame_cnt`=0.
- Handshake at cycle *t* → `dtx`/`dsync` valid at *t*+1.
- First sample at *t*+1+(`clk_div`+1).
- `m_axis_tvalid` rises 1 cycle after GAP ends.
- Frame length: (F+1)·2·(`clk_div`+1) cycles, where F is the number of frame bits.
- `clk_div`=0 gives the fastest rate, `clk`/2 per bit. Must work.
- Asynchronous reset mid-frame:
  - all outputs return to reset values immediately;
  - a partially shifted RX word is discarded;
  - a TX word already accepted is lost.

## Configuration
- `BIDIR_PARITY_EN` defined:
  - The frame is `TX_WIDTH`+1 bits; the final bit is even parity of the TX payload.
  - The RX window is the last `RX_WIDTH`+1 bits; its final bit is even parity over RX.
  - On mismatch, the word is still published and `parity_err` is set.
- Not defined: frame = `TX_WIDTH` bits; `parity_err` is tied 0.
- Port list is identical in both builds.

## Structure
- Package `bidir_serdes_pkg`:
  - state enum `serdes_state_t` (IDLE/SHIFT/GAP);
  - `FRAME_CNT_W`=16;
  - function `frame_bits(width)` adding the parity bit under the macro.
- Sub-module `bidir_bit_timer`:
  - half-period counter;
  - produces `launch`/`sample` strobes and `txclk` from latched `clk_div` and `sck_pol`;
  - `run` input clears the counter when low.

## Test plan
- `clk_div`=0, `sck_pol`=0, send TX 0xA5A5_0000_FFFF with `drx` looping `dtx`:
  - 49 bit-periods to IDLE;
  - RX = 0xFFFF with `tlast` matching;
  - `frame_cnt`=1.
- `clk_div`=3, `sck_pol`=1:
  - `txclk` idles high, period 8 cycles;
  - `dsync` high exactly 8 cycles;
  - `dtx` stable across each sample edge.
- Hold `m_axis_tready`=0, send 2 frames:
  - first word held;
  - `rx_overflow`=1;
  - second word dropped;
  - release `tready` → exactly one beat.
- Deassert `enable` mid-frame:
  - frame completes;
  - `s_axis_tready` stays 0 afterwards;
  - `busy` falls after GAP.
- Assert `rst_n`=0 at bit 20:
  - outputs return to reset values immediately;
  - next frame after release is correct.
- With `BIDIR_PARITY_EN`, flip the `drx` parity bit:
  - word is published;
  - `parity_err`=1;
  - clean frame leaves `parity_err` unchanged (sticky).

Source files
------------

// File: rtl/bidir_frame_serdes_pkg.sv
// Shared state type, counter width and frame sizing for bidir_frame_serdes.
// Defining BIDIR_PARITY_EN appends an even-parity bit to every frame.
package bidir_serdes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } serdes_state_t;

    localparam int unsigned FRAME_CNT_W = 16;

    // Bits on the wire for a payload of the given width
    function automatic int unsigned frame_bits(input int unsigned width);
`ifdef BIDIR_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/bidir_frame_serdes_if.sv
// TX (s_axis) and RX (m_axis) stream bundle between the FIFOs and the serdes.
// slave is the serdes view; master is the FIFO/test view.
interface bidir_frame_serdes_if #(
    parameter int unsigned TX_WIDTH = 48,
    parameter int unsigned RX_WIDTH = 16
);
    logic [TX_WIDTH-1:0] s_axis_tdata;
    logic                s_axis_tvalid;
    logic                s_axis_tlast;
    logic                s_axis_tready;
    logic [RX_WIDTH-1:0] m_axis_tdata;
    logic                m_axis_tvalid;
    logic                m_axis_tlast;
    logic                m_axis_tready;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/bidir_frame_serdes_bit_timer.sv
// Half-bit period counter: launch/sample strobes flag the edge ending the current cycle.
// txclk_c rests at pol and takes the opposite level in the second half of each shifted bit.
module bidir_bit_timer #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             toggle_en,
    input  logic             pol,
    input  logic [DIV_W-1:0] div,
    output logic             launch_c,
    output logic             sample_c,
    output logic             txclk_c
);

    logic [DIV_W-1:0] cnt;
    logic             phase;
    logic             term_c;

    assign term_c   = (cnt == div);
    assign sample_c = run & term_c & ~phase;
    assign launch_c = run & term_c & phase;
    assign txclk_c  = pol ^ (phase & toggle_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!run) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (term_c) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= DIV_W'(cnt + 1'b1);
        end
    end

endmodule

// File: rtl/bidir_frame_serdes.sv
// Full-duplex frame serializer/deserializer between the stream FIFOs and DTX/DRX/DSYNC/txclk.
// Optional even-parity bit per frame under BIDIR_PARITY_EN.
module bidir_frame_serdes
    import bidir_serdes_pkg::*;
#(
    parameter int unsigned TX_WIDTH = 48,
    parameter int unsigned RX_WIDTH = 16,
    parameter int unsigned DIV_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   sck_pol,
    input  logic [DIV_W-1:0]       clk_div,
    bidir_frame_serdes_if.slave    axis,
    output logic                   txclk,
    output logic                   dtx,
    output logic                   dsync,
    input  logic                   drx,
    output logic                   busy,
    output logic                   rx_overflow,
    output logic                   parity_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int unsigned FRAME_BITS = frame_bits(TX_WIDTH);
    localparam int unsigned RX_BITS    = frame_bits(RX_WIDTH);
    localparam int unsigned RX_START   = FRAME_BITS - RX_BITS;
    localparam int unsigned IDX_W      = $clog2(FRAME_BITS);

    if (RX_WIDTH > TX_WIDTH) begin : g_width_check
        $error("bidir_frame_serdes: RX_WIDTH must not exceed TX_WIDTH");
    end

    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [TX_WIDTH-1:0] d);
`ifdef BIDIR_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    serdes_state_t           state, state_d;
    logic [IDX_W-1:0]        bit_idx, bit_idx_d;
    logic [FRAME_BITS-1:0]   tx_sr, tx_sr_d;
    logic [RX_BITS-1:0]      rx_sr, rx_sr_d;
    logic                    tlast_q, tlast_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic                    pol_q, pol_d;
    logic                    dtx_d, dsync_d, busy_d;
    logic                    s_tready_q, s_tready_d;
    logic [RX_WIDTH-1:0]     m_tdata_q, m_tdata_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic                    m_tlast_q, m_tlast_d;
    logic                    rx_overflow_d, parity_err_d;
    logic [FRAME_CNT_W-1:0]  frame_cnt_d;
    logic                    launch_c, sample_c, tmr_pol_c;

    assign axis.s_axis_tready = s_tready_q;
    assign axis.m_axis_tdata  = m_tdata_q;
    assign axis.m_axis_tvalid = m_tvalid_q;
    assign axis.m_axis_tlast  = m_tlast_q;

    // Idle txclk follows the live polarity; frames use the latched one
    assign tmr_pol_c = (state == IDLE) ? sck_pol : pol_q;

    bidir_bit_timer #(.DIV_W(DIV_W)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (state != IDLE),
        .toggle_en (state == SHIFT),
        .pol       (tmr_pol_c),
        .div       (div_q),
        .launch_c  (launch_c),
        .sample_c  (sample_c),
        .txclk_c   (txclk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_idx     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            tlast_q     <= 1'b0;
            div_q       <= '0;
            pol_q       <= 1'b0;
            dtx         <= 1'b0;
            dsync       <= 1'b0;
            busy        <= 1'b0;
            s_tready_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            rx_overflow <= 1'b0;
            parity_err  <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_d;
            bit_idx     <= bit_idx_d;
            tx_sr       <= tx_sr_d;
            rx_sr       <= rx_sr_d;
            tlast_q     <= tlast_d;
            div_q       <= div_d;
            pol_q       <= pol_d;
            dtx         <= dtx_d;
            dsync       <= dsync_d;
            busy        <= busy_d;
            s_tready_q  <= s_tready_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            rx_overflow <= rx_overflow_d;
            parity_err  <= parity_err_d;
            frame_cnt   <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d       = state;
        bit_idx_d     = bit_idx;
        tx_sr_d       = tx_sr;
        rx_sr_d       = rx_sr;
        tlast_d       = tlast_q;
        div_d         = div_q;
        pol_d         = pol_q;
        dtx_d         = dtx;
        dsync_d       = dsync;
        m_tdata_d     = m_tdata_q;
        m_tvalid_d    = m_tvalid_q & ~axis.m_axis_tready;
        m_tlast_d     = m_tlast_q;
        rx_overflow_d = rx_overflow;
        parity_err_d  = parity_err;
        frame_cnt_d   = frame_cnt;

        unique case (state)
            IDLE: begin
                if (s_tready_q && axis.s_axis_tvalid) begin
                    state_d   = SHIFT;
                    bit_idx_d = '0;
                    tx_sr_d   = frame_word(axis.s_axis_tdata);
                    dtx_d     = tx_sr_d[FRAME_BITS-1];
                    dsync_d   = 1'b1;
                    rx_sr_d   = '0;
                    tlast_d   = axis.s_axis_tlast;
                    div_d     = clk_div;
                    pol_d     = sck_pol;
                end
            end
            SHIFT: begin
                // Only the tail of the frame carries RX payload
                if (sample_c && (bit_idx >= IDX_W'(RX_START)))
                    rx_sr_d = {rx_sr[RX_BITS-2:0], drx};
                if (launch_c) begin
                    dsync_d = 1'b0;
                    if (bit_idx == IDX_W'(FRAME_BITS - 1)) begin
                        state_d = GAP;
                        dtx_d   = 1'b0;
                    end else begin
                        bit_idx_d = IDX_W'(bit_idx + 1'b1);
                        tx_sr_d   = tx_sr << 1;
                        dtx_d     = tx_sr_d[FRAME_BITS-1];
                    end
                end
            end
            GAP: begin
                if (launch_c) begin
                    state_d     = IDLE;
                    frame_cnt_d = FRAME_CNT_W'(frame_cnt + 1'b1);
                    if (!m_tvalid_q || axis.m_axis_tready) begin
                        m_tdata_d  = rx_sr[RX_BITS-1 -: RX_WIDTH];
                        m_tlast_d  = tlast_q;
                        m_tvalid_d = 1'b1;
                    end else begin
                        rx_overflow_d = 1'b1;
                    end
`ifdef BIDIR_PARITY_EN
                    if (^rx_sr)
                        parity_err_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        s_tready_d = (state_d == IDLE) & enable;
        busy_d     = (state_d != IDLE);
    end

endmodule

// File: tb/tb_bidir_frame_serdes.sv
// Directed + randomized bench for bidir_frame_serdes against a per-bit frame model.
// Honours BIDIR_PARITY_EN to size frames and predict parity_err.
module tb_bidir_frame_serdes;

`ifdef BIDIR_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int TXW      = 48;
    localparam int RXW      = 16;
    localparam int F        = TXW + PAR;
    localparam int RX_START = F - (RXW + PAR);

    logic        clk = 1'b0;
    logic        rst_n, enable, sck_pol, drx;
    logic [7:0]  clk_div;
    logic        txclk, dtx, dsync, busy, rx_overflow, parity_err;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int beats  = 0;

    logic        exp_v, exp_l, exp_ovf, exp_perr;
    logic [15:0] exp_d, exp_cnt;

    bidir_frame_serdes_if #(.TX_WIDTH(TXW), .RX_WIDTH(RXW)) axis ();

    bidir_frame_serdes #(.TX_WIDTH(TXW), .RX_WIDTH(RXW), .DIV_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sck_pol     (sck_pol),
        .clk_div     (clk_div),
        .axis        (axis),
        .txclk       (txclk),
        .dtx         (dtx),
        .dsync       (dsync),
        .drx         (drx),
        .busy        (busy),
        .rx_overflow (rx_overflow),
        .parity_err  (parity_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && axis.m_axis_tvalid && axis.m_axis_tready) beats <= beats + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_v = 0; exp_l = 0; exp_d = '0; exp_ovf = 0; exp_perr = 0; exp_cnt = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txclk"}, txclk, sck_pol);
        check({tag, "_dtx"}, dtx, 0);
        check({tag, "_dsync"}, dsync, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_s_tready"}, axis.s_axis_tready, 0);
        check({tag, "_m_tvalid"}, axis.m_axis_tvalid, 0);
        check({tag, "_m_tdata"}, axis.m_axis_tdata, 0);
        check({tag, "_m_tlast"}, axis.m_axis_tlast, 0);
        check({tag, "_ovf"}, rx_overflow, 0);
        check({tag, "_perr"}, parity_err, 0);
        check({tag, "_cnt"}, frame_cnt, 0);
    endtask

    // One frame: build wire bit lists, drive drx per bit period, check pins every cycle
    task automatic run_frame(input logic [47:0] tx, input logic tl, input logic [7:0] div,
                             input logic pol, input logic loopback, input logic [15:0] rxw,
                             input logic flip, input int en_drop, input int rst_at);
        logic        txb [0:63];
        logic        rxb [0:63];
        logic [15:0] exp_word;
        logic        win_par, got, ab, e;
        int          hp;
        for (int k = 0; k < 64; k++) begin txb[k] = 1'b0; rxb[k] = 1'b0; end
        for (int k = 0; k < TXW; k++) txb[k] = tx[TXW-1-k];
        if (PAR == 1) txb[TXW] = ^tx;
        for (int k = 0; k < F; k++) rxb[k] = loopback ? txb[k] : 1'($urandom);
        if (!loopback) begin
            for (int j = 0; j < RXW; j++) rxb[RX_START+j] = rxw[RXW-1-j];
            if (PAR == 1) rxb[F-1] = ^rxw;
        end
        if (PAR == 1) rxb[F-1] = rxb[F-1] ^ flip;
        exp_word = '0;
        win_par  = 1'b0;
        for (int j = 0; j < RXW; j++) exp_word = {exp_word[14:0], rxb[RX_START+j]};
        for (int j = RX_START; j < F; j++) win_par = win_par ^ rxb[j];

        sck_pol = pol;
        clk_div = div;
        axis.s_axis_tdata  = tx;
        axis.s_axis_tlast  = tl;
        axis.s_axis_tvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (axis.s_axis_tready) got = 1'b1;
            @(posedge clk); #1;
        end
        axis.s_axis_tvalid = 1'b0;
        check("handshake", got, 1);
        clk_div = ~div;
        hp = int'(div) + 1;
        ab = 1'b0;
        for (int k = 0; k <= F && !ab; k++) begin
            for (int c = 0; c < 2 * hp && !ab; c++) begin
                drx = (k < F) ? rxb[k] : 1'b0;
                if (k == en_drop && c == 0) enable = 1'b0;
                if (k == rst_at && c == 1) begin
                    #2 rst_n = 1'b0;
                    #1 check_reset_outputs("midrst");
                    model_reset();
                    ab = 1'b1;
                    @(negedge clk); rst_n = 1'b1;
                    @(posedge clk); #1;
                end else begin
                    @(negedge clk);
                    e = pol ^ (k < F && c >= hp);
                    check("txclk", txclk, e);
                    e = (k < F) ? txb[k] : 1'b0;
                    check("dtx", dtx, e);
                    check("dsync", dsync, k == 0);
                    check("busy", busy, 1);
                    check("s_tready_busy", axis.s_axis_tready, 0);
                    @(posedge clk); #1;
                end
            end
        end
        if (!ab) begin
            if (!exp_v || axis.m_axis_tready) begin
                exp_v = 1'b1; exp_d = exp_word; exp_l = tl;
            end else begin
                exp_ovf = 1'b1;
            end
            if (PAR == 1 && win_par) exp_perr = 1'b1;
            exp_cnt = exp_cnt + 16'd1;
            @(negedge clk);
            check("busy_idle", busy, 0);
            check("txclk_idle", txclk, sck_pol);
            check("dtx_idle", dtx, 0);
            check("dsync_idle", dsync, 0);
            check("s_tready_idle", axis.s_axis_tready, enable);
            check("m_tvalid", axis.m_axis_tvalid, exp_v);
            check("m_tdata", axis.m_axis_tdata, exp_d);
            check("m_tlast", axis.m_axis_tlast, exp_l);
            check("rx_overflow", rx_overflow, exp_ovf);
            check("parity_err", parity_err, exp_perr);
            check("frame_cnt", frame_cnt, exp_cnt);
            @(posedge clk); #1;
            if (axis.m_axis_tready) exp_v = 1'b0;
        end
    endtask

    initial begin
        int b0;
        rst_n = 1'b0; enable = 1'b1; sck_pol = 1'b0; clk_div = 8'd0; drx = 1'b0;
        axis.s_axis_tdata = '0; axis.s_axis_tvalid = 1'b0; axis.s_axis_tlast = 1'b0;
        axis.m_axis_tready = 1'b1;
        model_reset();
        #1 check_reset_outputs("rst");
        sck_pol = 1'b1;
        #1 check("rst_txclk_follows_pol", txclk, 1);
        sck_pol = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("tready_first_cycle", axis.s_axis_tready, 0);
        @(posedge clk); #1;
        check("tready_after_enable", axis.s_axis_tready, 1);

        // Loopback at the fastest rate
        run_frame(48'hA5A5_0000_FFFF, 1'b1, 8'd0, 1'b0, 1'b1, 16'h0, 1'b0, -1, -1);
        // Slow rate, inverted clock idle, independent RX data
        run_frame(48'h1234_5678_9ABC, 1'b0, 8'd3, 1'b1, 1'b0, 16'hC3A5, 1'b0, -1, -1);

        // Back-pressure: second word dropped, one beat on release
        axis.m_axis_tready = 1'b0;
        run_frame(48'h0F0F_F0F0_1357, 1'b1, 8'd1, 1'b0, 1'b0, 16'h8001, 1'b0, -1, -1);
        run_frame(48'hFFFF_0000_2468, 1'b0, 8'd0, 1'b0, 1'b0, 16'h7FFE, 1'b0, -1, -1);
        b0 = beats;
        axis.m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_v = 1'b0;
        check("one_beat", beats - b0, 1);
        check("tvalid_after_release", axis.m_axis_tvalid, 0);

        // Enable dropped mid-frame
        run_frame(48'hDEAD_BEEF_CAFE, 1'b1, 8'd2, 1'b0, 1'b1, 16'h0, 1'b0, 10, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("tready_disabled", axis.s_axis_tready, 0);
            check("busy_disabled", busy, 0);
        end
        enable = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset at bit 20, then a clean frame
        run_frame(48'h5555_AAAA_3C3C, 1'b1, 8'd1, 1'b0, 1'b1, 16'h0, 1'b0, -1, 20);
        run_frame(48'h0000_1111_BEEF, 1'b1, 8'd1, 1'b1, 1'b1, 16'h0, 1'b0, -1, -1);

        // Corrupted parity bit, then a clean frame (error stays sticky)
        run_frame(48'h1111_2222_3333, 1'b0, 8'd0, 1'b0, 1'b0, 16'h4C4D, 1'b1, -1, -1);
        run_frame(48'h4444_5555_6666, 1'b1, 8'd0, 1'b0, 1'b0, 16'h0F31, 1'b0, -1, -1);

        for (int n = 0; n < 5; n++) begin
            run_frame({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, 1'($urandom),
                      8'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                      16'($urandom), 1'($urandom), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
